mem_port: RTL and testbench

Bus-master front end that drives the shared word-addressed memory on behalf of the ANNA CPU core's fetch and load/store paths. It accepts one read or write request at a time over a valid/ready handshake, drives the memory's `r_en`/`w_en`/`addr`/`w_data` strobes for exactly one cycle, and captures the memory's negedge-registered `r_data`. It returns the result over a valid/ready response channel. It sits between the core and the memory, and is the only agent allowed to drive the memory port.

---
 rtl/mem_port_if.sv | 28 ++
 rtl/mem_port.sv | 114 +++++++++++
 tb/tb_mem_port.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Core-side request/response channel of mem_port.
// master = core (fetch/LSU), slave = mem_port.
interface mem_port_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_port.sv
// mem_port: single-outstanding bus master for the shared word memory.
// Ports: clk, reset (sync, active-high), core (mem_port_if.slave
// req/rsp handshake), mem_r_en/mem_w_en/mem_addr/mem_w_data strobes
// out, mem_r_data in (negedge-registered by memory), busy.
// Optional: define MEM_PORT_BOUNDS_EN to reject addresses > ADDR_LIMIT.
module mem_port #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter logic [ADDR_SIZE-1:0] ADDR_LIMIT = {ADDR_SIZE{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_if.slave            core,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_w_data,
  input  logic [WORD_SIZE-1:0] mem_r_data,
  output logic                 busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

`ifdef MEM_PORT_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [1:0]           state;
  logic                 ready_q;
  logic                 valid_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 err_q;
  logic                 accept;
  logic                 oob;

  assign accept = core.req_valid && ready_q;
  assign oob    = BOUNDS_EN &&
                  (core.req_addr > ADDR_LIMIT);

  assign core.req_ready = ready_q;
  assign core.rsp_valid = valid_q;
  assign core.rsp_rdata = rdata_q;
  assign core.rsp_err   = err_q;
  assign busy           = (state != IDLE);

  // req_ready is registered so it reads 0 during reset
  // and rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_addr   <= '0;
      mem_w_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            if (oob) begin
              // Rejected: no strobe, answer at once.
              state   <= RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state    <= ACCESS;
              mem_addr <= core.req_addr;
              mem_r_en <= !core.req_we;
              mem_w_en <= core.req_we;
              if (core.req_we)
                mem_w_data <= core.req_wdata;
            end
          end
        end
        ACCESS: begin
          // Memory updated r_data on the mid-cycle negedge;
          // writes echo the stored word.
          state    <= RESP;
          mem_r_en <= 1'b0;
          mem_w_en <= 1'b0;
          valid_q  <= 1'b1;
          err_q    <= 1'b0;
          rdata_q  <= mem_r_data;
        end
        RESP: begin
          if (core.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ready_q  <= 1'b0;
          valid_q  <= 1'b0;
          mem_r_en <= 1'b0;
          mem_w_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port with a negedge word-memory model.
// Bounds scenario follows MEM_PORT_BOUNDS_EN.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_r_en, mem_w_en, busy;
  logic [15:0] mem_addr, mem_w_data;
  logic [15:0] mem_r_data = 16'h0000;
  logic [15:0] mem [0:65535];

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int r_cnt = 0;
  int w_cnt = 0;
  int both_cnt = 0;

  mem_port_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bus ();

  mem_port #(
    .WORD_SIZE(16), .ADDR_SIZE(16),
    .ADDR_LIMIT(16'h0FFF)
  ) dut (
    .clk(clk), .reset(reset), .core(bus),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_r_en) r_cnt <= r_cnt + 1;
    if (mem_w_en) w_cnt <= w_cnt + 1;
    if (mem_r_en && mem_w_en) both_cnt <= both_cnt + 1;
    if (mem_w_en) begin
      mem[mem_addr] = mem_w_data;
      mem_r_data <= mem_w_data;
    end else if (mem_r_en) begin
      mem_r_data <= mem[mem_addr];
    end
  end

  task automatic send(input logic we, input logic [15:0] a,
                      input logic [15:0] d, input bit hold,
                      output int acc);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errs++;
      $display("FAIL send_wait: req_ready=%b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
         mem_r_en, mem_w_en, mem_addr, mem_w_data, busy} !== '0) begin
      errs++;
      $display("FAIL reset_outs: rdy=%b v=%b d=%h e=%b r=%b w=%b a=%h wd=%h b=%b want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
               mem_r_en, mem_w_en, mem_addr, mem_w_data, busy);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: req_ready=%b busy=%b want 1 0",
               bus.req_ready, busy);
    end
  endtask

  task automatic test_write();
    int acc, w0;
    w0 = w_cnt;
    bus.rsp_ready = 1'b1;
    send(1'b1, 16'h0042, 16'hBEEF, 1'b0, acc);
    checks++;
    if ({mem_w_en, mem_r_en, busy, bus.rsp_valid} !== 4'b1010 ||
        mem_addr !== 16'h0042 || mem_w_data !== 16'hBEEF) begin
      errs++;
      $display("FAIL wr_access: w=%b r=%b busy=%b v=%b a=%h d=%h want 1 0 1 0 0042 beef",
               mem_w_en, mem_r_en, busy, bus.rsp_valid, mem_addr, mem_w_data);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF ||
        mem_w_en !== 1'b0) begin
      errs++;
      $display("FAIL wr_resp: v=%b d=%h w=%b want 1 beef 0",
               bus.rsp_valid, bus.rsp_rdata, mem_w_en);
    end
    checks++;
    if (w_cnt - w0 !== 1) begin
      errs++;
      $display("FAIL wr_pulse: cycles=%0d want 1", w_cnt - w0);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL wr_done: v=%b rdy=%b want 0 1",
               bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_read();
    int acc, r0;
    r0 = r_cnt;
    send(1'b0, 16'h0042, 16'h0000, 1'b0, acc);
    checks++;
    if (mem_r_en !== 1'b1 || mem_w_en !== 1'b0 ||
        mem_addr !== 16'h0042) begin
      errs++;
      $display("FAIL rd_access: r=%b w=%b a=%h want 1 0 0042",
               mem_r_en, mem_w_en, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF ||
        r_cnt - r0 !== 1 || mem_r_en !== 1'b0) begin
      errs++;
      $display("FAIL rd_resp: v=%b d=%h pulses=%0d r=%b want 1 beef 1 0",
               bus.rsp_valid, bus.rsp_rdata, r_cnt - r0, mem_r_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int acc, r0, bad;
    r0 = r_cnt;
    bad = 0;
    bus.rsp_ready = 1'b0;
    send(1'b0, 16'h0042, 16'h0000, 1'b0, acc);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF ||
          bus.req_ready !== 1'b0 || mem_r_en || mem_w_en)
        bad++;
    end
    checks++;
    if (bad != 0 || r_cnt - r0 !== 1) begin
      errs++;
      $display("FAIL stall_hold: bad_cycles=%0d pulses=%0d want 0 1",
               bad, r_cnt - r0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL stall_release: v=%b busy=%b rdy=%b want 0 0 1",
               bus.rsp_valid, busy, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, b0;
    b0 = both_cnt;
    bus.rsp_ready = 1'b1;
    send(1'b1, 16'h0010, 16'h1111, 1'b1, a0);
    send(1'b1, 16'h0011, 16'h2222, 1'b1, a1);
    send(1'b0, 16'h0010, 16'h0000, 1'b0, a2);
    checks++;
    if (a1 - a0 != 3 || a2 - a1 != 3) begin
      errs++;
      $display("FAIL b2b_spacing: gaps=%0d,%0d want 3,3",
               a1 - a0, a2 - a1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h1111) begin
      errs++;
      $display("FAIL b2b_read: v=%b d=%h want 1 1111",
               bus.rsp_valid, bus.rsp_rdata);
    end
    checks++;
    if (both_cnt != b0) begin
      errs++;
      $display("FAIL b2b_overlap: count=%0d want 0", both_cnt - b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int acc, seen;
    seen = 0;
    bus.rsp_ready = 1'b1;
    send(1'b0, 16'h0042, 16'h0000, 1'b0, acc);
    reset = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || mem_r_en !== 1'b0 ||
        mem_w_en !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_edge: v=%b r=%b w=%b busy=%b want 0 0 0 0",
               bus.rsp_valid, mem_r_en, mem_w_en, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL abort_req_in_reset: busy=%b rdy=%b want 0 0",
               busy, bus.req_ready);
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen != 0 || bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort_no_rsp: rsp_cycles=%0d rdy=%b want 0 1",
               seen, bus.req_ready);
    end
  endtask

  task automatic test_bounds();
    int acc, r0;
    bus.rsp_ready = 1'b1;
    send(1'b1, 16'h0FFF, 16'hCAFE, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 16'h0FFF, 16'h0000, 1'b0, acc);
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hCAFE ||
        bus.rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL bnd_limit_ok: v=%b d=%h e=%b want 1 cafe 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    @(posedge clk); #1;
`ifdef MEM_PORT_BOUNDS_EN
    r0 = r_cnt;
    send(1'b0, 16'h1000, 16'h0000, 1'b0, acc);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
        bus.rsp_rdata !== 16'h0000 || mem_r_en || mem_w_en) begin
      errs++;
      $display("FAIL bnd_oob: v=%b e=%b d=%h r=%b w=%b want 1 1 0000 0 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
               mem_r_en, mem_w_en);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        r_cnt != r0) begin
      errs++;
      $display("FAIL bnd_oob_done: v=%b rdy=%b pulses=%0d want 0 1 0",
               bus.rsp_valid, bus.req_ready, r_cnt - r0);
    end
`else
    send(1'b1, 16'h1000, 16'h1234, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    r0 = r_cnt;
    send(1'b0, 16'h1000, 16'h0000, 1'b0, acc);
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 16'h1234 || r_cnt - r0 != 1) begin
      errs++;
      $display("FAIL bnd_off: v=%b e=%b d=%h pulses=%0d want 1 0 1234 1",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, r_cnt - r0);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_bounds();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
